muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative unsigned multiply/divide controller for the execute stage. It borrows the shared 32-bit ALU, sequencing its add (control 0) and subtract (control 1) operations over WIDTH cycles to produce a 2·WIDTH-bit product or a quotient/remainder pair. The execute-stage operand mux selects this block's ALU drive whenever BusyE is high, and the hazard logic stalls the pipeline on BusyE.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 forces reset immediately.
- StartE  in  1  operation request; sampled only in IDLE.
- OpE  in  1  operation select: 0 = MULU, 1 = DIVU.
- SrcAE  in  WIDTH  multiplicand or dividend; captured with StartE.
- SrcBE  in  WIDTH  multiplier or divisor; captured with StartE.
- BusyE  out  1  high whenever the state is not IDLE.
- DoneE  out  1  one-cycle pulse when the result becomes valid.
- HiE  out  WIDTH  product upper half, or remainder.
- LoE  out  WIDTH  product lower half, or quotient.
- AluSrcA  out  WIDTH  ALU operand A drive.
- AluSrcB  out  WIDTH  ALU operand B drive.
- AluControl  out  3  ALU operation code drive.
- AluResult  in  WIDTH  ALU result return; combinational from AluSrcA/AluSrcB/AluControl.

## Operation
- States: IDLE, MUL, DIV, DONE. Iteration counter is clog2(WIDTH)+1 bits.
- IDLE:
  - StartE=1 captures both operands and loads the counter with WIDTH.
  - OpE=0 goes to MUL. OpE=1 with SrcBE≠0 goes to DIV. OpE=1 with SrcBE=0 goes to DONE.
- MUL (shift-add). Registers P_hi=0, P_lo=SrcBE, M=SrcAE.
  - Each cycle drives AluSrcA=P_hi, AluSrcB=M, AluControl=0.
  - Carry = (AluResult < P_hi), unsigned compare inside this block.
  - If P_lo[0]=1: {P_hi,P_lo} ← {carry,AluResult,P_lo} >> 1.
  - Otherwise: {P_hi,P_lo} ← {1'b0,P_hi,P_lo} >> 1.
- DIV (restoring). Registers R=0, Q=dividend, D=divisor.
  - S = {R[WIDTH-2:0], Q[WIDTH-1]}.
  - Each cycle drives AluSrcA=S, AluSrcB=D, AluControl=1.
  - If R[WIDTH-1]=1 or S ≥ D (unsigned): R ← AluResult, Q ← {Q[WIDTH-2:0],1}.
  - Otherwise: R ← S, Q ← {Q[WIDTH-2:0],0}.
  - All arithmetic is modulo 2^WIDTH. The discarded top bit of S is accounted for by the R[WIDTH-1] test.
- Counter decrements once per MUL/DIV cycle. When it reaches 1, the next state is DONE.
- DONE, entered from MUL/DIV:
  - MUL: HiE ← P_hi, LoE ← P_lo.
  - DIV: HiE ← R (remainder), LoE ← Q (quotient).
- DONE, entered by divide-by-zero: HiE ← dividend, LoE ← all ones.
- DONE: DoneE=1 for exactly this cycle; next state is IDLE unconditionally.
- HiE/LoE are registered. They hold their value until the next DONE or a reset.
- StartE is ignored in MUL, DIV and DONE. There is no queueing.
- Outside MUL/DIV: AluSrcA=0, AluSrcB=0, AluControl=0.

## Timing
- Reset state: IDLE, BusyE=0, DoneE=0, HiE=0, LoE=0, AluSrcA=0, AluSrcB=0, AluControl=0, all internal registers 0.
- Reset asserted mid-operation: aborts at once, returns to IDLE, clears HiE/LoE. No DoneE is produced for the aborted operation.
- Normal latency:
  - StartE sampled at edge N.
  - Iterations run in cycles N+1 … N+WIDTH.
  - DoneE=1 and HiE/LoE valid in cycle N+WIDTH+1 (N+33 for WIDTH=32).
- Divide-by-zero latency: DoneE=1 in cycle N+1.
- BusyE:
  - Rises in cycle N+1 and stays high through the DoneE cycle.
  - Goes low in cycle N+WIDTH+2.
  - The earliest next accepted StartE is at the edge ending cycle N+WIDTH+2 (IDLE).
- ALU path: AluSrcA/AluSrcB/AluControl are combinational from state and registers. AluResult is consumed in the same cycle.

## Test plan
- MULU 7×6, WIDTH=32 → DoneE in cycle N+33, HiE=0x00000000, LoE=0x0000002A; AluControl=0 in all 32 iteration cycles.
- MULU 0xFFFFFFFF×0xFFFFFFFF → HiE=0xFFFFFFFE, LoE=0x00000001 (exercises the carry path).
- DIVU 100÷7 → LoE=14, HiE=2. DIVU 0xFFFFFFFF÷1 → LoE=0xFFFFFFFF, HiE=0. DIVU 0x80000000÷0xFFFFFFFF → LoE=0, HiE=0x80000000 (exercises R[31]).
- DIVU 5÷0 → DoneE in cycle N+1, HiE=5, LoE=0xFFFFFFFF, BusyE high for exactly one cycle.
- Pulse StartE with OpE=0, 3×3, during iteration 10 of a running 7×6 → ignored; result is LoE=42. A new StartE in the IDLE cycle after DONE is accepted.
- Drop reset to 0 during iteration 10 → within the same cycle BusyE=0, HiE=LoE=0, AluSrcA/B=0; no DoneE follows; a subsequent 7×6 completes normally.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage bundle between the pipeline/ALU side and the multiply/divide
// sequencer. The master side owns the request and the shared ALU result. The
// slave side (the sequencer) owns status, results and the ALU operand drive.
interface muldivSequencerIf #(
    parameter int WIDTH = 32
);
    logic             StartE;
    logic             OpE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             BusyE;
    logic             DoneE;
    logic [WIDTH-1:0] HiE;
    logic [WIDTH-1:0] LoE;
    logic [WIDTH-1:0] AluSrcA;
    logic [WIDTH-1:0] AluSrcB;
    logic [2:0]       AluControl;
    logic [WIDTH-1:0] AluResult;

    modport master (
        output StartE, OpE, SrcAE, SrcBE, AluResult,
        input  BusyE, DoneE, HiE, LoE, AluSrcA, AluSrcB, AluControl
    );

    modport slave (
        input  StartE, OpE, SrcAE, SrcBE, AluResult,
        output BusyE, DoneE, HiE, LoE, AluSrcA, AluSrcB, AluControl
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) sequencer.
// It borrows the shared ALU for one add or subtract per cycle over WIDTH
// cycles. It holds the pipeline through BusyE until the registered result is
// presented with a one-cycle DoneE pulse.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    muldivSequencerIf.slave   bus
);
    localparam int CNTW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } seqStateT;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;

    seqStateT         state, stateNext;
    logic [CNTW-1:0]  count, countNext;
    // acc: P_hi / remainder R, shiftReg: P_lo / quotient Q,
    // operand: multiplicand M / divisor D.
    logic [WIDTH-1:0] acc, accNext;
    logic [WIDTH-1:0] shiftReg, shiftNext;
    logic [WIDTH-1:0] operand, operandNext;
    logic [WIDTH-1:0] hiReg, hiNext;
    logic [WIDTH-1:0] loReg, loNext;
    logic [WIDTH-1:0] aluA, aluB;
    logic [2:0]       aluCtl;

    // Add carry-out recovered from the ALU sum, which wraps below P_hi on overflow.
    logic             carry;
    // Partial remainder shifted left with the next dividend bit.
    logic [WIDTH-1:0] divS;
    // A set top bit of R means S really has WIDTH+1 bits and is certainly >= D.
    logic             divTake;

    assign carry   = (bus.AluResult < acc);
    assign divS    = {acc[WIDTH-2:0], shiftReg[WIDTH-1]};
    assign divTake = acc[WIDTH-1] | (divS >= operand);

    // State and datapath registers; reset aborts any operation and clears results.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, whatever order they are written in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            acc      <= '0;
            shiftReg <= '0;
            operand  <= '0;
            hiReg    <= '0;
            loReg    <= '0;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            acc      <= accNext;
            shiftReg <= shiftNext;
            operand  <= operandNext;
            hiReg    <= hiNext;
            loReg    <= loNext;
        end
    end

    // Next-state, iteration datapath and ALU drive.
    // NOTE: every output of this block gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        stateNext   = state;
        countNext   = count;
        accNext     = acc;
        shiftNext   = shiftReg;
        operandNext = operand;
        hiNext      = hiReg;
        loNext      = loReg;
        aluA        = '0;
        aluB        = '0;
        aluCtl      = ALU_ADD;

        case (state)
            IDLE: begin
                if (bus.StartE) begin
                    accNext   = '0;
                    countNext = CNTW'(WIDTH);
                    if (!bus.OpE) begin
                        operandNext = bus.SrcAE;
                        shiftNext   = bus.SrcBE;
                        stateNext   = MUL;
                    end else begin
                        operandNext = bus.SrcBE;
                        shiftNext   = bus.SrcAE;
                        if (bus.SrcBE != '0) begin
                            stateNext = DIV;
                        end else begin
                            // Divide by zero skips the iterations entirely.
                            stateNext = DONE;
                            hiNext    = bus.SrcAE;
                            loNext    = '1;
                        end
                    end
                end
            end

            MUL: begin
                aluA      = acc;
                aluB      = operand;
                aluCtl    = ALU_ADD;
                countNext = count - 1'b1;
                if (shiftReg[0]) begin
                    accNext   = {carry, bus.AluResult[WIDTH-1:1]};
                    shiftNext = {bus.AluResult[0], shiftReg[WIDTH-1:1]};
                end else begin
                    accNext   = {1'b0, acc[WIDTH-1:1]};
                    shiftNext = {acc[0], shiftReg[WIDTH-1:1]};
                end
                if (count == CNTW'(1)) begin
                    stateNext = DONE;
                    hiNext    = accNext;
                    loNext    = shiftNext;
                end
            end

            DIV: begin
                aluA      = divS;
                aluB      = operand;
                aluCtl    = ALU_SUB;
                countNext = count - 1'b1;
                if (divTake) begin
                    accNext   = bus.AluResult;
                    shiftNext = {shiftReg[WIDTH-2:0], 1'b1};
                end else begin
                    accNext   = divS;
                    shiftNext = {shiftReg[WIDTH-2:0], 1'b0};
                end
                if (count == CNTW'(1)) begin
                    stateNext = DONE;
                    hiNext    = accNext;
                    loNext    = shiftNext;
                end
            end

            DONE: begin
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.BusyE      = (state != IDLE);
    assign bus.DoneE      = (state == DONE);
    assign bus.HiE        = hiReg;
    assign bus.LoE        = loReg;
    assign bus.AluSrcA    = aluA;
    assign bus.AluSrcB    = aluB;
    assign bus.AluControl = aluCtl;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer. The ALU is modelled here, and
// expected results come from plain 64-bit multiply, / and %.
module tb_muldiv_sequencer;
    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    muldivSequencerIf #(.WIDTH(WIDTH)) bus ();

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Shared ALU: control 0 adds, control 1 subtracts.
    assign bus.AluResult = (bus.AluControl == 3'd0) ? bus.AluSrcA + bus.AluSrcB :
                           (bus.AluControl == 3'd1) ? bus.AluSrcA - bus.AluSrcB : '0;

    // Reference: the arithmetic result and the cycle in which DoneE must appear.
    task automatic model(input bit op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output int lat);
        logic [63:0] p;
        lat = WIDTH + 1;
        if (!op) begin
            p  = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi  = a;
            lo  = 32'hFFFF_FFFF;
            lat = 1;
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endtask

    // Issues one operation from a negedge in IDLE and observes it up to the
    // following IDLE cycle. Optionally pulses StartE (3x3 MULU) in iteration 10.
    task automatic doOp(input bit op, input logic [31:0] a, input logic [31:0] b,
                        input bit injectStart,
                        output int lat, output int busyCycles, output bit busyAfter,
                        output logic [31:0] hi, output logic [31:0] lo,
                        output int aluBad, output int holdBad);
        logic [31:0] hi0, lo0;
        hi0        = bus.HiE;
        lo0        = bus.LoE;
        aluBad     = 0;
        holdBad    = 0;
        busyCycles = 0;
        bus.StartE = 1'b1;
        bus.OpE    = op;
        bus.SrcAE  = a;
        bus.SrcBE  = b;
        @(negedge clk);
        bus.StartE = 1'b0;
        bus.OpE    = 1'($urandom);
        bus.SrcAE  = $urandom;
        bus.SrcBE  = $urandom;
        lat        = 1;
        while (!bus.DoneE && lat < 100) begin
            if (bus.BusyE) busyCycles++;
            if (bus.AluControl !== (op ? 3'd1 : 3'd0)) aluBad++;
            if (bus.HiE !== hi0 || bus.LoE !== lo0) holdBad++;
            if (injectStart && lat == 10) begin
                bus.StartE = 1'b1;
                bus.OpE    = 1'b0;
                bus.SrcAE  = 32'd3;
                bus.SrcBE  = 32'd3;
            end else begin
                bus.StartE = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus.StartE = 1'b0;
        if (bus.BusyE) busyCycles++;
        if (bus.AluSrcA !== '0 || bus.AluSrcB !== '0 || bus.AluControl !== 3'd0) aluBad++;
        hi = bus.HiE;
        lo = bus.LoE;
        @(negedge clk);
        busyAfter = bus.BusyE | bus.DoneE;
    endtask

    task automatic test_reset;
        bus.StartE = 1'b0;
        bus.OpE    = 1'b0;
        bus.SrcAE  = '0;
        bus.SrcBE  = '0;
        #1 reset = 1'b0;
        #2;
        total++;
        if ({bus.BusyE, bus.DoneE} !== 2'b00 || bus.HiE !== '0 || bus.LoE !== '0) begin
            bad++;
            $display("FAIL reset status: got busy=%b done=%b hi=%h lo=%h want all 0",
                     bus.BusyE, bus.DoneE, bus.HiE, bus.LoE);
        end
        total++;
        if (bus.AluSrcA !== '0 || bus.AluSrcB !== '0 || bus.AluControl !== 3'd0) begin
            bad++;
            $display("FAIL reset alu drive: got a=%h b=%h ctl=%0d want 0", bus.AluSrcA,
                     bus.AluSrcB, bus.AluControl);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mulu;
        logic [31:0] ta[4], tb[4];
        logic [31:0] hi, lo, eHi, eLo;
        int lat, eLat, busy, aluBad, holdBad;
        bit busyAfter;
        ta = '{32'd7, 32'hFFFF_FFFF, 32'd0, 32'h1234_5678};
        tb = '{32'd6, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'd1};
        for (int i = 0; i < 4; i++) begin
            model(1'b0, ta[i], tb[i], eHi, eLo, eLat);
            doOp(1'b0, ta[i], tb[i], 1'b0, lat, busy, busyAfter, hi, lo, aluBad, holdBad);
            total++;
            if ({hi, lo} !== {eHi, eLo}) begin
                bad++;
                $display("FAIL mulu[%0d] result: got hi=%h lo=%h want hi=%h lo=%h", i, hi, lo, eHi, eLo);
            end
            total++;
            if (lat !== eLat) begin
                bad++;
                $display("FAIL mulu[%0d] latency: got %0d want %0d", i, lat, eLat);
            end
            total++;
            if (busy !== eLat || busyAfter !== 1'b0) begin
                bad++;
                $display("FAIL mulu[%0d] busy: got %0d cycles after=%b want %0d cycles after=0", i, busy, busyAfter, eLat);
            end
            total++;
            if (aluBad !== 0 || holdBad !== 0) begin
                bad++;
                $display("FAIL mulu[%0d] alu/hold: got %0d/%0d bad cycles want 0/0", i, aluBad, holdBad);
            end
        end
    endtask

    task automatic test_divu;
        logic [31:0] ta[5], tb[5];
        logic [31:0] hi, lo, eHi, eLo;
        int lat, eLat, busy, aluBad, holdBad;
        bit busyAfter;
        ta = '{32'd100, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'hFFFF_FFFE};
        tb = '{32'd7, 32'd1, 32'hFFFF_FFFF, 32'd100, 32'h8000_0001};
        for (int i = 0; i < 5; i++) begin
            model(1'b1, ta[i], tb[i], eHi, eLo, eLat);
            doOp(1'b1, ta[i], tb[i], 1'b0, lat, busy, busyAfter, hi, lo, aluBad, holdBad);
            total++;
            if ({hi, lo} !== {eHi, eLo}) begin
                bad++;
                $display("FAIL divu[%0d] result: got rem=%h quo=%h want rem=%h quo=%h", i, hi, lo, eHi, eLo);
            end
            total++;
            if (lat !== eLat) begin
                bad++;
                $display("FAIL divu[%0d] latency: got %0d want %0d", i, lat, eLat);
            end
            total++;
            if (busy !== eLat || busyAfter !== 1'b0) begin
                bad++;
                $display("FAIL divu[%0d] busy: got %0d cycles after=%b want %0d cycles after=0", i, busy, busyAfter, eLat);
            end
            total++;
            if (aluBad !== 0 || holdBad !== 0) begin
                bad++;
                $display("FAIL divu[%0d] alu/hold: got %0d/%0d bad cycles want 0/0", i, aluBad, holdBad);
            end
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] ta[2];
        logic [31:0] hi, lo, eHi, eLo;
        int lat, eLat, busy, aluBad, holdBad;
        bit busyAfter;
        ta = '{32'd5, 32'hCAFE_0000};
        for (int i = 0; i < 2; i++) begin
            model(1'b1, ta[i], 32'd0, eHi, eLo, eLat);
            doOp(1'b1, ta[i], 32'd0, 1'b0, lat, busy, busyAfter, hi, lo, aluBad, holdBad);
            total++;
            if ({hi, lo} !== {eHi, eLo}) begin
                bad++;
                $display("FAIL divzero[%0d] result: got hi=%h lo=%h want hi=%h lo=%h", i, hi, lo, eHi, eLo);
            end
            total++;
            if (lat !== eLat) begin
                bad++;
                $display("FAIL divzero[%0d] latency: got %0d want %0d", i, lat, eLat);
            end
            total++;
            if (busy !== 1 || busyAfter !== 1'b0) begin
                bad++;
                $display("FAIL divzero[%0d] busy: got %0d cycles after=%b want 1 cycle after=0", i, busy, busyAfter);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, hi, lo, eHi, eLo;
        int lat, eLat, busy, aluBad, holdBad;
        bit busyAfter, op;
        for (int i = 0; i < 40; i++) begin
            op = 1'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 15);
                3:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            model(op, a, b, eHi, eLo, eLat);
            doOp(op, a, b, 1'b0, lat, busy, busyAfter, hi, lo, aluBad, holdBad);
            total++;
            if ({hi, lo} !== {eHi, eLo}) begin
                bad++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h want hi=%h lo=%h",
                         i, op, a, b, hi, lo, eHi, eLo);
            end
            total++;
            if (lat !== eLat || busy !== eLat || busyAfter !== 1'b0) begin
                bad++;
                $display("FAIL random[%0d] timing: got lat=%0d busy=%0d after=%b want lat=busy=%0d after=0",
                         i, lat, busy, busyAfter, eLat);
            end
            total++;
            if (aluBad !== 0 || holdBad !== 0) begin
                bad++;
                $display("FAIL random[%0d] alu/hold: got %0d/%0d bad cycles want 0/0", i, aluBad, holdBad);
            end
        end
    endtask

    // StartE mid-operation is ignored; StartE in the IDLE cycle after DONE is taken.
    task automatic test_start_ignored;
        logic [31:0] hi, lo;
        int lat, busy, aluBad, holdBad;
        bit busyAfter;
        doOp(1'b0, 32'd7, 32'd6, 1'b1, lat, busy, busyAfter, hi, lo, aluBad, holdBad);
        total++;
        if ({hi, lo} !== {32'd0, 32'd42} || lat !== 33) begin
            bad++;
            $display("FAIL start_ignored: got hi=%h lo=%h lat=%0d want hi=0 lo=2a lat=33", hi, lo, lat);
        end
        total++;
        if (busyAfter !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored idle: got busy/done=%b want 0", busyAfter);
        end
        doOp(1'b0, 32'd12, 32'd12, 1'b0, lat, busy, busyAfter, hi, lo, aluBad, holdBad);
        total++;
        if ({hi, lo} !== {32'd0, 32'd144} || lat !== 33) begin
            bad++;
            $display("FAIL start_after_done: got hi=%h lo=%h lat=%0d want hi=0 lo=90 lat=33", hi, lo, lat);
        end
    endtask

    task automatic test_back_to_back;
        bit          ops[3];
        logic [31:0] ta[3], tb[3];
        logic [31:0] hi, lo, eHi, eLo;
        int lat, eLat, busy, aluBad, holdBad;
        bit busyAfter;
        ops = '{1'b1, 1'b0, 1'b1};
        ta  = '{32'd9, 32'h0001_0001, 32'd1000};
        tb  = '{32'd0, 32'h0001_0001, 32'd33};
        for (int i = 0; i < 3; i++) begin
            model(ops[i], ta[i], tb[i], eHi, eLo, eLat);
            doOp(ops[i], ta[i], tb[i], 1'b0, lat, busy, busyAfter, hi, lo, aluBad, holdBad);
            total++;
            if ({hi, lo} !== {eHi, eLo} || lat !== eLat) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                         i, hi, lo, lat, eHi, eLo, eLat);
            end
        end
    endtask

    // Reset during iteration 10 aborts immediately with no DoneE afterwards.
    task automatic test_reset_abort;
        logic [31:0] hi, lo;
        int lat, busy, aluBad, holdBad, doneSeen;
        bit busyAfter;
        doOp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, busy, busyAfter, hi, lo, aluBad, holdBad);
        bus.StartE = 1'b1;
        bus.OpE    = 1'b0;
        bus.SrcAE  = 32'd7;
        bus.SrcBE  = 32'd6;
        @(negedge clk);
        bus.StartE = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (bus.BusyE !== 1'b0 || bus.DoneE !== 1'b0 || bus.HiE !== '0 || bus.LoE !== '0) begin
            bad++;
            $display("FAIL reset_abort status: got busy=%b done=%b hi=%h lo=%h want all 0",
                     bus.BusyE, bus.DoneE, bus.HiE, bus.LoE);
        end
        total++;
        if (bus.AluSrcA !== '0 || bus.AluSrcB !== '0) begin
            bad++;
            $display("FAIL reset_abort alu: got a=%h b=%h want 0", bus.AluSrcA, bus.AluSrcB);
        end
        @(negedge clk);
        reset    = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.DoneE || bus.BusyE) doneSeen++;
            @(negedge clk);
        end
        total++;
        if (doneSeen !== 0) begin
            bad++;
            $display("FAIL reset_abort no_done: got %0d busy/done cycles want 0", doneSeen);
        end
        doOp(1'b0, 32'd7, 32'd6, 1'b0, lat, busy, busyAfter, hi, lo, aluBad, holdBad);
        total++;
        if ({hi, lo} !== {32'd0, 32'd42} || lat !== 33 || holdBad !== 0) begin
            bad++;
            $display("FAIL reset_abort rerun: got hi=%h lo=%h lat=%0d hold=%0d want hi=0 lo=2a lat=33 hold=0",
                     hi, lo, lat, holdBad);
        end
    endtask

    initial begin
        test_reset();
        test_mulu();
        test_divu();
        test_div_zero();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
